// File: rtl/hwag_angle_gen.sv
// ---------------------------------------------------------------------------
// hwag_angle_gen
//
// Fine crank-angle interpolator behind the crank-wheel sync core (60-2 wheel).
// Every real tooth edge loads the tooth number and derives a sub-step period
// from the tooth period that just finished. The tooth pitch is then split into
// 2^STEP_SHIFT sub-steps, each lasting step_period clk cycles. After the last
// real tooth (TOOTH_LAST) the two missing teeth are synthesised so the angle
// keeps running across the gap.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active high
//   sync         in   high while the sync core is locked
//   tooth_stb    in   one-cycle strobe per real tooth edge
//   period_in    in   clk count of the tooth period that just finished
//   tooth_num    in   number of the tooth that just started
//   angle        out  {tooth, sub-step}
//   angle_stb    out  pulse in every cycle where angle takes a new value
//   angle_valid  out  high once a tooth has been loaded since sync rose
//   step_lost    out  pulse when a tooth arrives before its sub-steps ran out
//
// State table
//   state | meaning
//   IDLE  | sync low or no tooth loaded yet; angle held at 0
//   RUN   | prescaler running, sub-steps advancing
//   STALL | all sub-steps (and virtual teeth) used, waiting for next tooth
// ---------------------------------------------------------------------------
module hwag_angle_gen #(
    parameter int PCNT_WIDTH = 24,
    parameter int TCNT_WIDTH = 6,
    parameter int STEP_SHIFT = 6,
    parameter int TOOTH_LAST = 57
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sync,
    input  logic                             tooth_stb,
    input  logic [PCNT_WIDTH-1:0]            period_in,
    input  logic [TCNT_WIDTH-1:0]            tooth_num,
    output logic [TCNT_WIDTH+STEP_SHIFT-1:0] angle,
    output logic                             angle_stb,
    output logic                             angle_valid,
    output logic                             step_lost
);

    localparam int SP_W = PCNT_WIDTH - STEP_SHIFT;
    localparam logic [STEP_SHIFT-1:0] SUB_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                  state;
    logic [SP_W-1:0]         step_period;
    logic [SP_W-1:0]         presc;
    logic [STEP_SHIFT-1:0]   sub;
    logic [TCNT_WIDTH-1:0]   tooth;
    logic [1:0]              virt_left;

    logic [SP_W-1:0]         step_period_new;
    logic [1:0]              virt_new;
    logic                    presc_tc;
    logic                    exhausted;

    // A period shorter than one sub-step would give a zero divider; clamp to 1
    // so the angle simply advances every cycle.
    always_comb begin
        step_period_new = period_in[PCNT_WIDTH-1:STEP_SHIFT];
        if (period_in < (PCNT_WIDTH'(1) << STEP_SHIFT)) begin
            step_period_new = SP_W'(1);
        end
    end

    assign virt_new  = (tooth_num == TCNT_WIDTH'(TOOTH_LAST)) ? 2'd2 : 2'd0;
    assign presc_tc  = (presc == step_period - SP_W'(1));
    // Nothing left to advance: last sub-step of the last (possibly virtual) tooth.
    assign exhausted = (sub == SUB_MAX) && (virt_left == 2'd0);

    // The angle is a direct concatenation of the tooth and sub-step registers.
    assign angle = {tooth, sub};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            step_period <= '0;
            presc       <= '0;
            sub         <= '0;
            tooth       <= '0;
            virt_left   <= '0;
            angle_stb   <= 1'b0;
            angle_valid <= 1'b0;
            step_lost   <= 1'b0;
        end else begin
            angle_stb <= 1'b0;
            step_lost <= 1'b0;

            if (!sync) begin
                state       <= IDLE;
                step_period <= '0;
                presc       <= '0;
                sub         <= '0;
                tooth       <= '0;
                virt_left   <= '0;
                angle_valid <= 1'b0;
            end else if (tooth_stb) begin
                // Load has priority over a coinciding prescaler terminal count;
                // that pending step is dropped.
                state       <= RUN;
                tooth       <= tooth_num;
                sub         <= '0;
                presc       <= '0;
                step_period <= step_period_new;
                virt_left   <= virt_new;
                angle_valid <= 1'b1;
                angle_stb   <= 1'b1;
                // Only a running tooth can lose steps; the first load after
                // sync rises comes from IDLE and a stalled tooth is exhausted.
                step_lost   <= (state == RUN) && !exhausted;
            end else begin
                case (state)
                    RUN: begin
                        if (presc_tc) begin
                            presc <= '0;
                            if (sub != SUB_MAX) begin
                                sub       <= sub + STEP_SHIFT'(1);
                                angle_stb <= 1'b1;
                            end else if (virt_left != 2'd0) begin
                                tooth     <= tooth + TCNT_WIDTH'(1);
                                sub       <= '0;
                                virt_left <= virt_left - 2'd1;
                                angle_stb <= 1'b1;
                            end else begin
                                state <= STALL;
                            end
                        end else begin
                            presc <= presc + SP_W'(1);
                        end
                    end
                    default: begin
                        // IDLE waits for a tooth, STALL holds angle and prescaler.
                    end
                endcase
            end
        end
    end

endmodule
